// File: rtl/ucode_pkg.sv
// Shared microword field layout and encodings for the microcode sequencer.
package ucode_pkg;

  typedef enum logic [2:0] {
    SEQ_NEXT     = 3'd0,
    SEQ_JUMP     = 3'd1,
    SEQ_BRANCH   = 3'd2,
    SEQ_CALL     = 3'd3,
    SEQ_RET      = 3'd4,
    SEQ_DISPATCH = 3'd5,
    SEQ_HALT     = 3'd6,
    SEQ_RSVD     = 3'd7
  } seq_op_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam int SEQ_LSB  = 0;
  localparam int SEQ_W    = 3;
  localparam int CSEL_LSB = 3;
  localparam int CSEL_W   = 2;
  localparam int CINV_BIT = 5;
  localparam int TGT_LSB  = 6;

endpackage

// File: rtl/ucode_ret_stack.sv
// Return-address LIFO; dout is the top entry, combinational. Push when full and pop when
// empty are ignored; clr empties it synchronously. Entries are never cleared, only sp.
module ucode_ret_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         full,
  output logic                         empty
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    top_idx;

  assign full    = (sp == SPW'(DEPTH));
  assign empty   = (sp == '0);
  assign wr_idx  = IW'(sp);
  assign top_idx = IW'(sp - SPW'(1));
  assign dout    = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (clr) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SPW'(1);
    end else if (pop && !empty) begin
      sp <= sp - SPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/ucode_sequencer.sv
// Micro-PC owner: decodes the sequencing field and issues one microword per cycle, no bubbles.
// stall, a DISPATCH without dispatch_valid, HALT and FAULT hold the micro-PC; restart overrides all.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    STACK_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [ADDR_WIDTH-1:0]            rom_addr,
  input  logic [DATA_WIDTH-1:0]            rom_data,
  input  logic [3:0]                       cond_in,
  input  logic [ADDR_WIDTH-1:0]            dispatch_addr,
  input  logic                             dispatch_valid,
  output logic                             dispatch_ready,
  input  logic                             stall,
  input  logic                             restart,
  output logic [DATA_WIDTH-ADDR_WIDTH-7:0] ctrl,
  output logic                             ctrl_valid,
  output logic                             halted,
  output logic                             fault
);

  localparam int SPW      = $clog2(STACK_DEPTH + 1);
  localparam int CTRL_LSB = TGT_LSB + ADDR_WIDTH;

  state_e                state, state_nxt;
  seq_op_e               seq_op;
  logic [ADDR_WIDTH-1:0] upc, upc_nxt, upc_inc, target, ret_addr;
  logic [CSEL_W-1:0]     cond_sel;
  logic                  cond, run, retire;
  logic                  stk_push, stk_pop, stk_full, stk_empty;
  logic [SPW-1:0]        stk_sp;

  assign seq_op   = seq_op_e'(rom_data[SEQ_LSB +: SEQ_W]);
  assign cond_sel = rom_data[CSEL_LSB +: CSEL_W];
  assign target   = rom_data[TGT_LSB +: ADDR_WIDTH];
  assign cond     = cond_in[cond_sel] ^ rom_data[CINV_BIT];
  assign upc_inc  = upc + ADDR_WIDTH'(1);

  // restart suppresses retirement so nothing reaches the datapath in the restart cycle
  assign run            = (state == ST_RUN) && !stall && !restart;
  assign retire         = run && !(seq_op == SEQ_DISPATCH && !dispatch_valid);
  assign dispatch_ready = run && (seq_op == SEQ_DISPATCH) && dispatch_valid;
  assign ctrl_valid     = retire;
  assign ctrl           = rom_data[DATA_WIDTH-1:CTRL_LSB];
  assign rom_addr       = upc;
  assign halted         = (state == ST_HALT);
  assign fault          = (state == ST_FAULT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upc   <= RESET_ADDR;
      state <= ST_RUN;
    end else begin
      upc   <= upc_nxt;
      state <= state_nxt;
    end
  end

  always_comb begin
    upc_nxt   = upc;
    state_nxt = state;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    if (restart) begin
      upc_nxt   = RESET_ADDR;
      state_nxt = ST_RUN;
    end else if (retire) begin
      case (seq_op)
        SEQ_JUMP:     upc_nxt = target;
        SEQ_BRANCH:   upc_nxt = cond ? target : upc_inc;
        SEQ_CALL: begin
          if (stk_full) begin
            state_nxt = ST_FAULT;
          end else begin
            stk_push = 1'b1;
            upc_nxt  = target;
          end
        end
        SEQ_RET: begin
          if (stk_empty) begin
            state_nxt = ST_FAULT;
          end else begin
            stk_pop = 1'b1;
            upc_nxt = ret_addr;
          end
        end
        SEQ_DISPATCH: upc_nxt   = dispatch_addr;
        SEQ_HALT:     state_nxt = ST_HALT;
        default:      upc_nxt   = upc_inc;
      endcase
    end
  end

  ucode_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .clr   (restart),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (upc_inc),
    .dout  (ret_addr),
    .sp    (stk_sp),
    .full  (stk_full),
    .empty (stk_empty)
  );

  sp_in_range: assert property (@(posedge clk) disable iff (rst) stk_sp <= SPW'(STACK_DEPTH));

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: vector table, directed corner sequences, randomized run against a model.
module tb_ucode_sequencer;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SD = 4;
  localparam int CW = DW - AW - 6;

  localparam int OP_NEXT = 0, OP_JUMP = 1, OP_BRANCH = 2, OP_CALL = 3;
  localparam int OP_RET = 4, OP_DISP = 5, OP_HALT = 6, OP_RSVD = 7;
  localparam int M_RUN = 0, M_HALT = 1, M_FAULT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [3:0]    cond_in;
  logic [AW-1:0] dispatch_addr;
  logic          dispatch_valid;
  logic          dispatch_ready;
  logic          stall;
  logic          restart;
  logic [CW-1:0] ctrl;
  logic          ctrl_valid;
  logic          halted;
  logic          fault;

  logic [DW-1:0] rom [256];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;
  always_comb rom_data = rom[rom_addr];

  ucode_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STACK_DEPTH(SD), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data), .cond_in(cond_in),
    .dispatch_addr(dispatch_addr), .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .stall(stall), .restart(restart), .ctrl(ctrl), .ctrl_valid(ctrl_valid),
    .halted(halted), .fault(fault)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] word;
    logic [3:0]  cond;
    logic        dv;
    logic [7:0]  daddr;
    logic        stl;
    logic        cv;
    logic        dr;
    logic [7:0]  nxt;
    logic        hlt;
  } vec_t;

  function automatic logic [31:0] mw(input int op, input int csel, input int inv, input int tgt, input int c);
    return {c[17:0], tgt[7:0], inv[0], csel[1:0], op[2:0]};
  endfunction

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Lands the micro-PC on address a: restart to 0, where a JUMP to a sits.
  task automatic goto(input logic [7:0] a);
    rom[0] = mw(OP_JUMP, 0, 0, a, 0);
    restart = 1'b1; stall = 1'b0; dispatch_valid = 1'b0;
    tick();
    restart = 1'b0;
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt [16];
    int m_upc, m_st, op, csel, inv, tgt;
    int stk [$];
    logic [31:0] w;
    logic cnd, ecv, edr;

    rst = 1'b1; cond_in = '0; dispatch_addr = '0; dispatch_valid = 1'b0;
    stall = 1'b0; restart = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = mw(OP_NEXT, 0, 0, 0, i + 32'h100);
    rom[3] = mw(OP_HALT, 0, 0, 0, 32'h3AB);

    // reset state and NEXT chain
    #1;
    chkv("reset rom_addr", 32'(rom_addr), 32'h0);
    chkb("reset halted", halted, 1'b0);
    chkb("reset fault", fault, 1'b0);
    chkb("reset dispatch_ready", dispatch_ready, 1'b0);
    chkb("reset ctrl_valid", ctrl_valid, 1'b1);
    chkv("reset ctrl", 32'(ctrl), 32'h100);
    #2 rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chkv($sformatf("chain rom_addr %0d", k), 32'(rom_addr), 32'(k));
      chkb($sformatf("chain ctrl_valid %0d", k), ctrl_valid, 1'b1);
    end
    tick();
    chkb("halt halted", halted, 1'b1);
    chkb("halt ctrl_valid", ctrl_valid, 1'b0);
    chkv("halt rom_addr", 32'(rom_addr), 32'h3);

    // single-step vector table
    vt[0]  = '{8'h10, mw(OP_BRANCH, 0, 0, 8'h40, 11), 4'b0001, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h40, 1'b0};
    vt[1]  = '{8'h10, mw(OP_BRANCH, 0, 0, 8'h40, 12), 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0};
    vt[2]  = '{8'h10, mw(OP_BRANCH, 0, 1, 8'h40, 13), 4'b0001, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0};
    vt[3]  = '{8'h10, mw(OP_BRANCH, 0, 1, 8'h40, 14), 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h40, 1'b0};
    vt[4]  = '{8'h10, mw(OP_BRANCH, 3, 0, 8'h77, 15), 4'b1000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h77, 1'b0};
    vt[5]  = '{8'h10, mw(OP_BRANCH, 2, 0, 8'h77, 16), 4'b1011, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0};
    vt[6]  = '{8'h10, mw(OP_BRANCH, 1, 1, 8'h77, 17), 4'b1101, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h77, 1'b0};
    vt[7]  = '{8'h10, mw(OP_JUMP, 0, 0, 8'hC3, 18), 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0};
    vt[8]  = '{8'h10, mw(OP_RSVD, 0, 0, 8'h55, 19), 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0};
    vt[9]  = '{8'h10, mw(OP_DISP, 0, 0, 8'h55, 20), 4'b0000, 1'b1, 8'h9A, 1'b0, 1'b1, 1'b1, 8'h9A, 1'b0};
    vt[10] = '{8'h10, mw(OP_DISP, 0, 0, 8'h55, 21), 4'b0000, 1'b0, 8'h9A, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0};
    vt[11] = '{8'h10, mw(OP_JUMP, 0, 0, 8'hC3, 22), 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0};
    vt[12] = '{8'h10, mw(OP_DISP, 0, 0, 8'h55, 23), 4'b0000, 1'b1, 8'h9A, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0};
    vt[13] = '{8'h10, mw(OP_HALT, 0, 0, 8'h55, 24), 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10, 1'b1};
    vt[14] = '{8'hFF, mw(OP_NEXT, 0, 0, 8'h55, 25), 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[15] = '{8'h10, mw(OP_BRANCH, 2, 0, 8'h20, 26), 4'b0100, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0};
    foreach (vt[i]) begin
      rom[vt[i].addr] = vt[i].word;
      goto(vt[i].addr);
      cond_in = vt[i].cond; dispatch_valid = vt[i].dv;
      dispatch_addr = vt[i].daddr; stall = vt[i].stl;
      #1;
      chkb($sformatf("vec%0d ctrl_valid", i), ctrl_valid, vt[i].cv);
      chkb($sformatf("vec%0d dispatch_ready", i), dispatch_ready, vt[i].dr);
      chkv($sformatf("vec%0d ctrl", i), 32'(ctrl), 32'(vt[i].word[31:14]));
      tick();
      stall = 1'b0; dispatch_valid = 1'b0; cond_in = '0;
      #1;
      chkv($sformatf("vec%0d next rom_addr", i), 32'(rom_addr), 32'(vt[i].nxt));
      chkb($sformatf("vec%0d halted", i), halted, vt[i].hlt);
    end

    // CALL / RET round trip
    rom[8'h20] = mw(OP_CALL, 0, 0, 8'h80, 0);
    rom[8'h80] = mw(OP_RET, 0, 0, 0, 0);
    goto(8'h20);
    chkv("call start", 32'(rom_addr), 32'h20);
    tick();
    chkv("call target", 32'(rom_addr), 32'h80);
    tick();
    chkv("ret address", 32'(rom_addr), 32'h21);

    // five nested CALLs overflow a depth-4 stack
    for (int k = 0; k < 5; k++) rom[8'h30 + k] = mw(OP_CALL, 0, 0, 8'h31 + k, 0);
    goto(8'h30);
    for (int k = 0; k < 4; k++) tick();
    chkv("nest fifth call addr", 32'(rom_addr), 32'h34);
    chkb("nest fifth call retires", ctrl_valid, 1'b1);
    chkb("nest no fault yet", fault, 1'b0);
    tick();
    chkb("nest fault", fault, 1'b1);
    chkv("nest rom_addr held", 32'(rom_addr), 32'h34);
    chkb("nest ctrl_valid", ctrl_valid, 1'b0);
    chkb("nest dispatch_ready", dispatch_ready, 1'b0);

    // RET on empty stack
    rom[8'h50] = mw(OP_RET, 0, 0, 0, 0);
    goto(8'h50);
    tick();
    chkb("ret underflow fault", fault, 1'b1);
    chkv("ret underflow addr", 32'(rom_addr), 32'h50);

    // self-call still pushes: fifth one faults
    rom[8'h60] = mw(OP_CALL, 0, 0, 8'h60, 0);
    goto(8'h60);
    for (int k = 0; k < 4; k++) tick();
    chkb("selfcall no fault after 4", fault, 1'b0);
    chkv("selfcall addr", 32'(rom_addr), 32'h60);
    tick();
    chkb("selfcall fault after 5", fault, 1'b1);

    // DISPATCH waits for dispatch_valid
    rom[8'h05] = mw(OP_DISP, 0, 0, 0, 0);
    goto(8'h05);
    for (int k = 0; k < 3; k++) begin
      #1;
      chkv($sformatf("dwait%0d rom_addr", k), 32'(rom_addr), 32'h05);
      chkb($sformatf("dwait%0d ctrl_valid", k), ctrl_valid, 1'b0);
      chkb($sformatf("dwait%0d dispatch_ready", k), dispatch_ready, 1'b0);
      tick();
    end
    dispatch_valid = 1'b1; dispatch_addr = 8'h9A;
    #1;
    chkb("dispatch ready", dispatch_ready, 1'b1);
    chkb("dispatch ctrl_valid", ctrl_valid, 1'b1);
    tick();
    dispatch_valid = 1'b0;
    #1;
    chkv("dispatch target", 32'(rom_addr), 32'h9A);

    // stall during a JUMP with one return address on the stack
    rom[8'h6E] = mw(OP_CALL, 0, 0, 8'h70, 0);
    rom[8'h70] = mw(OP_JUMP, 0, 0, 8'hA0, 0);
    rom[8'hA0] = mw(OP_RET, 0, 0, 0, 0);
    goto(8'h6E);
    tick();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chkv($sformatf("stall%0d rom_addr", k), 32'(rom_addr), 32'h70);
      chkb($sformatf("stall%0d ctrl_valid", k), ctrl_valid, 1'b0);
      tick();
    end
    stall = 1'b0;
    #1;
    chkb("unstall ctrl_valid", ctrl_valid, 1'b1);
    tick();
    chkv("unstall jump", 32'(rom_addr), 32'hA0);
    tick();
    chkv("stack kept through stall", 32'(rom_addr), 32'h6F);
    chkb("stack kept no fault", fault, 1'b0);

    // HALT, then restart together with stall
    rom[8'h90] = mw(OP_HALT, 0, 0, 0, 0);
    goto(8'h90);
    tick();
    chkb("halt2 halted", halted, 1'b1);
    stall = 1'b1; restart = 1'b1;
    #1;
    chkb("restart halted until edge", halted, 1'b1);
    chkb("restart ctrl_valid", ctrl_valid, 1'b0);
    tick();
    stall = 1'b0; restart = 1'b0;
    #1;
    chkv("restart rom_addr", 32'(rom_addr), 32'h00);
    chkb("restart halted cleared", halted, 1'b0);

    // restart in RUN suppresses an accepted dispatch
    goto(8'h05);
    dispatch_valid = 1'b1; dispatch_addr = 8'h33; restart = 1'b1;
    #1;
    chkb("restart blocks dispatch_ready", dispatch_ready, 1'b0);
    chkb("restart blocks ctrl_valid", ctrl_valid, 1'b0);
    tick();
    restart = 1'b0; dispatch_valid = 1'b0;
    #1;
    chkv("restart over dispatch", 32'(rom_addr), 32'h00);

    // asynchronous rst mid-CALL clears upc and sp
    goto(8'h20);
    tick();
    chkv("pre-rst rom_addr", 32'(rom_addr), 32'h80);
    rst = 1'b1;
    #1;
    chkv("async rst rom_addr", 32'(rom_addr), 32'h00);
    rst = 1'b0;
    rom[0] = mw(OP_RET, 0, 0, 0, 0);
    tick();
    chkb("rst cleared sp (ret faults)", fault, 1'b1);
    chkv("rst ret addr held", 32'(rom_addr), 32'h00);

    // randomized run against the reference model
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w[2:0] == 3'd6 && $urandom_range(0, 3) != 0) w[2:0] = 3'd0;
      rom[i] = w;
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    m_upc = 0; m_st = M_RUN; stk.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      cond_in = 4'($urandom);
      stall = ($urandom_range(0, 3) == 0);
      dispatch_valid = 1'($urandom_range(0, 1));
      dispatch_addr = 8'($urandom);
      restart = ($urandom_range(0, 31) == 0) || (m_st != M_RUN && $urandom_range(0, 3) == 0);
      #1;
      w = rom[m_upc];
      op = int'(w) & 7; csel = (int'(w) >> 3) & 3; inv = (int'(w) >> 5) & 1; tgt = (int'(w) >> 6) & 255;
      cnd = cond_in[csel] ^ inv[0];
      ecv = !restart && m_st == M_RUN && !stall && !(op == OP_DISP && !dispatch_valid);
      edr = !restart && m_st == M_RUN && !stall && op == OP_DISP && dispatch_valid;
      chkv("rand rom_addr", 32'(rom_addr), 32'(m_upc));
      chkb("rand halted", halted, m_st == M_HALT);
      chkb("rand fault", fault, m_st == M_FAULT);
      chkb("rand ctrl_valid", ctrl_valid, ecv);
      chkb("rand dispatch_ready", dispatch_ready, edr);
      chkv("rand ctrl", 32'(ctrl), 32'(w[31:14]));
      if (restart) begin
        m_upc = 0; m_st = M_RUN; stk.delete();
      end else if (ecv) begin
        case (op)
          OP_JUMP:   m_upc = tgt;
          OP_BRANCH: m_upc = cnd ? tgt : (m_upc + 1) % 256;
          OP_CALL: begin
            if (stk.size() == SD) m_st = M_FAULT;
            else begin stk.push_back((m_upc + 1) % 256); m_upc = tgt; end
          end
          OP_RET: begin
            if (stk.size() == 0) m_st = M_FAULT;
            else m_upc = stk.pop_back();
          end
          OP_DISP:   m_upc = int'(dispatch_addr);
          OP_HALT:   m_st = M_HALT;
          default:   m_upc = (m_upc + 1) % 256;
        endcase
      end
      tick();
    end
    restart = 1'b0; stall = 1'b0; dispatch_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
- Microcode sequencer that owns the address input of the asynchronous microcode ROM and decides which microword executes each cycle.
- Holds the micro-PC and a small return-address stack. Decodes the sequencing field of the current microword.
- Exports the remaining control field to the datapath, qualified by a valid strobe.
- Sits between the instruction decoder, which supplies dispatch addresses, and the microcode ROM.

Parameters:
- ADDR_WIDTH, 8, microcode ROM address width; micro-PC width.
- DATA_WIDTH, 32, microword width. Must be >= ADDR_WIDTH+7.
- STACK_DEPTH, 4, return-stack entries (>=1).
- RESET_ADDR, 0, micro-PC value after reset or restart.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- rom_addr  out  ADDR_WIDTH  address to microcode ROM; equals micro-PC register.
- rom_data  in  DATA_WIDTH  microword returned combinationally for rom_addr.
- cond_in  in  4  datapath condition flags (Z, N, C, V in bits 0..3).
- dispatch_addr  in  ADDR_WIDTH  entry point from instruction decoder.
- dispatch_valid  in  1  dispatch_addr is valid.
- dispatch_ready  out  1  dispatch accepted this cycle.
- stall  in  1  datapath cannot accept a microword this cycle.
- restart  in  1  synchronous return to RESET_ADDR.
- ctrl  out  DATA_WIDTH-ADDR_WIDTH-6  control field of the current microword.
- ctrl_valid  out  1  current microword retires this cycle.
- halted  out  1  state is HALT.
- fault  out  1  state is FAULT.

Behaviour:
- Microword layout, LSB first:
  - [2:0] seq_op
  - [4:3] cond_sel
  - [5] cond_inv
  - [6+:ADDR_WIDTH] target
  - remainder: ctrl
- cond = cond_in[cond_sel] ^ cond_inv.
- States are RUN, HALT and FAULT.
- Reset values: upc=RESET_ADDR, sp=0, state=RUN. All outputs are combinational from these registers and rom_data.
  - At reset: rom_addr=RESET_ADDR, halted=0, fault=0, dispatch_ready=0.
  - ctrl_valid at reset follows the retire equation below.
- retire = (state==RUN) & !stall & !(seq_op==DISPATCH & !dispatch_valid).
- ctrl_valid = retire. ctrl is passed through unconditionally; consumers qualify it with ctrl_valid.
- Next-state and upc update happen only on retire; otherwise upc, sp and state hold. The exception is restart.
- Latency: a microword is presented the same cycle upc holds its address. The successor address is registered at the retiring edge, giving one microword per cycle with no bubbles.
- seq_op encoding:
  - 0 NEXT: upc+1, wrapping modulo 2**ADDR_WIDTH.
  - 1 JUMP: upc=target.
  - 2 BRANCH: upc = cond ? target : upc+1.
  - 3 CALL: push upc+1, then upc=target. If sp==STACK_DEPTH, go to FAULT with no push and upc held.
  - 4 RET: pop into upc. If sp==0, go to FAULT with upc held.
  - 5 DISPATCH: upc=dispatch_addr. dispatch_ready = (state==RUN) & !stall & dispatch_valid. While dispatch_valid is low, the same microword is re-presented.
  - 6 HALT: go to HALT; upc held. ctrl_valid is 1 for that cycle only.
  - 7 reserved: behaves as NEXT.
- HALT and FAULT: ctrl_valid=0 and dispatch_ready=0. Only restart or rst leaves these states.
- restart: overrides stall and every state. Next edge sets upc=RESET_ADDR, sp=0, state=RUN. The current microword does not retire: ctrl_valid is forced 0 and dispatch_ready is forced 0 in that cycle.
- rst asserted mid-operation clears immediately, asynchronously. Stack contents are not cleared; sp=0 makes them unreachable.
- CALL with target equal to upc is legal (self-call); the push still occurs.

Decomposition:
- Package ucode_pkg holds:
  - seq_op_e enum with the 3-bit encodings above.
  - state_e enum (RUN/HALT/FAULT).
  - Field offset/width constants: SEQ_LSB=0, CSEL_LSB=3, CINV_BIT=5, TGT_LSB=6.
- One sub-module, ucode_ret_stack: a parameterised LIFO (push, pop, data in/out, sp, full, empty) with async active-high reset of sp only.

Test Plan:
- Reset then NEXT chain at 0,1,2 -> rom_addr sequence 0,1,2,3; ctrl_valid=1 each cycle. A NEXT placed at 0xFF wraps rom_addr to 0x00.
- BRANCH at 0x10 (cond_sel=0, target 0x40), run twice: with cond_in=4'b0001 -> 0x40; with cond_in=0 -> 0x11. Repeat with cond_inv=1 and check the results swap.
- CALL at 0x20 to 0x80, RET at 0x80 -> rom_addr 0x20, 0x80, 0x21. Five nested CALLs with STACK_DEPTH=4 -> fault=1 after the fifth; rom_addr stays on the fifth CALL; ctrl_valid=0.
- DISPATCH at 0x05 with dispatch_valid low for 3 cycles, then high with dispatch_addr=0x9A -> rom_addr stays 0x05 and ctrl_valid=0 for 3 cycles; then dispatch_ready=1 for one cycle; next rom_addr=0x9A.
- stall held 2 cycles during a JUMP -> upc and sp unchanged, ctrl_valid=0. After stall drops, the JUMP retires once.
- HALT, then restart together with stall=1 -> halted=1 until the restart edge; then rom_addr=RESET_ADDR and state RUN. A rst pulse mid-CALL gives rom_addr=RESET_ADDR immediately with sp=0.
